// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bundle for imem_loader.
// chk_expected and checksum exist only when LOADER_CHECKSUM_EN is defined.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W-2:0] words_written;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_expected;
  logic [7:0]        checksum;

  modport master (
    output start, byte_in, byte_valid, byte_last, chk_expected,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error,
           words_written, checksum
  );
  modport slave (
    input  start, byte_in, byte_valid, byte_last, chk_expected,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error,
           words_written, checksum
  );
`else
  modport master (
    output start, byte_in, byte_valid, byte_last,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error,
           words_written
  );
  modport slave (
    input  start, byte_in, byte_valid, byte_last,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error,
           words_written
  );
`endif
endinterface

// File: rtl/imem_loader.sv
// Assembles a byte stream into big-endian words and writes them to instruction memory,
// holding the CPU until the image is in. LOADER_CHECKSUM_EN adds an image checksum check.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting bytes, writing each completed word
// PAD    | zero-filling a short final word before writing it
// FINISH | image complete, pulse done, release cpu_hold (unless checksum mismatch)
// ERR    | image overran memory, pulse done, flag error, keep cpu_hold
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_FINISH, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-2:0] words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       asm_word;
  logic              accept;

  assign accept = bus.byte_valid && (state_q == S_LOAD);

  always_comb begin
    asm_word = word_q;
    case (lane_q)
      2'd0:    asm_word[31:24] = bus.byte_in;
      2'd1:    asm_word[23:16] = bus.byte_in;
      2'd2:    asm_word[15:8]  = bus.byte_in;
      default: asm_word[7:0]   = bus.byte_in;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    waddr_d = waddr_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    error_d = error_q;
    chk_d   = chk_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          word_d  = '0;
          lane_d  = '0;
          waddr_d = '0;
          words_d = '0;
          error_d = 1'b0;
          hold_d  = 1'b1;
          chk_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          chk_d  = chk_q + bus.byte_in;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = waddr_q;
            wdata_d = asm_word;
            word_d  = '0;
            waddr_d = waddr_q + WORD_STEP;
            words_d = words_q + 1'b1;
            if (bus.byte_last)
              state_d = S_FINISH;
            else if (waddr_q == LAST_ADDR)
              state_d = S_ERR;
          end else begin
            word_d = asm_word;
            if (bus.byte_last)
              state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        // unfilled lanes are already zero: word_q is cleared after every write
        we_d    = 1'b1;
        addr_d  = waddr_q;
        wdata_d = word_q;
        word_d  = '0;
        lane_d  = '0;
        waddr_d = waddr_q + WORD_STEP;
        words_d = words_q + 1'b1;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = S_IDLE;
`ifdef LOADER_CHECKSUM_EN
        if (chk_q != bus.chk_expected) begin
          error_d = 1'b1;
          hold_d  = 1'b1;
        end
`endif
      end
      S_ERR: begin
        done_d  = 1'b1;
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      waddr_q <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      waddr_q <= waddr_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
      chk_q   <= chk_d;
    end
  end

  assign bus.byte_ready    = (state_q == S_LOAD);
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.cpu_hold      = hold_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.words_written = words_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.checksum      = chk_q;
`endif

endmodule
